// File: rtl/demux1_4_hs.sv
// demux1_4_hs: single-entry registered 1-to-4 demultiplexer with a
// valid/ready handshake on both sides and per-channel transfer counters.

// Per-channel completed-transfer counter, wraps modulo 2^CW.
module demux1_4_hs_cnt #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc_i,
  output logic [CW-1:0] cnt_o
);

  logic [CW-1:0] cnt_q;

  // Count one completion per drain; the natural overflow gives the wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     cnt_q <= '0;
    else if (inc_i) cnt_q <= cnt_q + CW'(1);
  end

  assign cnt_o = cnt_q;

endmodule

module demux1_4_hs #(
  parameter int DW = 2,
  parameter int CW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      sel,
  input  logic [DW-1:0]   din,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [3:0]      out_valid,
  input  logic [3:0]      out_ready,
  output logic [DW-1:0]   dout,
  output logic [4*CW-1:0] xfer_cnt
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [1:0]    ch_q;
  logic [DW-1:0] dout_q;
  logic          full, drain, accept;

  assign full   = (state_q == FULL);
  // Only the addressed channel's ready matters; the rest are ignored.
  assign drain  = full & out_ready[ch_q];
  // Entry frees up when empty or when it drains this same edge.
  assign in_ready = ~full | out_ready[ch_q];
  assign accept   = in_valid & in_ready;

  assign out_valid = full ? (4'b0001 << ch_q) : 4'b0000;
  assign dout      = dout_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // Next state: an accept always leaves the entry full; a lone drain empties it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (drain && !accept) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // Capture {sel, din} only on accept; otherwise the entry holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_q   <= 2'd0;
      dout_q <= '0;
    end else if (accept) begin
      ch_q   <= sel;
      dout_q <= din;
    end
  end

  // One counter per channel, bumped by that channel's drain only.
  for (genvar k = 0; k < 4; k++) begin : g_ch
    demux1_4_hs_cnt #(.CW(CW)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc_i (drain && (ch_q == 2'(k))),
      .cnt_o (xfer_cnt[k*CW +: CW])
    );
  end

endmodule

// File: tb/tb_demux1_4_hs.sv
// Directed bench for demux1_4_hs (DW=2, CW=2 so counter wrap is reachable).
module tb_demux1_4_hs;

  localparam int DW = 2;
  localparam int CW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [1:0]      sel;
  logic [DW-1:0]   din;
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      out_valid;
  logic [3:0]      out_ready;
  logic [DW-1:0]   dout;
  logic [4*CW-1:0] xfer_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int drains;

  demux1_4_hs #(.DW(DW), .CW(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sel       (sel),
    .din       (din),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .xfer_cnt  (xfer_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 4'b0000;
    sel       = 2'd0;
    din       = '0;
    rst_n     = 1'b0;
    tick();
    rst_n     = 1'b1;
  endtask

  // Reference drain count, from the observed handshake on the outputs.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) drains <= 0;
    else if (|(out_valid & out_ready)) drains <= drains + 1;
  end

  // Per-cycle invariants: one-hot-or-zero valid, counters track drains.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("onehot0", 32'($onehot0(out_valid)), 32'd1);
      chk("cnt_sum", 32'((xfer_cnt[1:0] + xfer_cnt[3:2] + xfer_cnt[5:4] + xfer_cnt[7:6]) & 3),
          32'(drains & 3));
    end
  end

  logic [1:0] s_vec [4];
  logic [1:0] d_vec [4];

  initial begin
    s_vec = '{2'd3, 2'd1, 2'd0, 2'd2};
    d_vec = '{2'b11, 2'b01, 2'b00, 2'b10};

    // Reset values held while rst_n is low.
    in_valid = 1'b0; out_ready = 4'b0000; sel = 2'd0; din = '0; rst_n = 1'b0;
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_cnt", 32'(xfer_cnt), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single transfer on channel 2, accepted on the first edge after reset.
    in_valid = 1'b1; sel = 2'd2; din = 2'b10; out_ready = 4'b0100;
    #1 chk("t1_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("t1_out_valid", 32'(out_valid), 32'b0100);
    chk("t1_dout", 32'(dout), 32'b10);
    tick();
    chk("t1_empty", 32'(out_valid), 32'd0);
    chk("t1_cnt", 32'(xfer_cnt), 32'h10);
    chk("t1_dout_hold", 32'(dout), 32'b10);

    // Back-to-back stream with channel changes every cycle.
    do_reset();
    in_valid = 1'b1; out_ready = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      sel = s_vec[i]; din = d_vec[i];
      #1 chk("t2_in_ready", 32'(in_ready), 32'd1);
      tick();
      chk("t2_out_valid", 32'(out_valid), 32'(4'b0001 << s_vec[i]));
      chk("t2_dout", 32'(dout), 32'(d_vec[i]));
    end
    in_valid = 1'b0;
    #1 chk("t2_in_ready_end", 32'(in_ready), 32'd1);
    tick();
    chk("t2_empty", 32'(out_valid), 32'd0);
    chk("t2_cnt", 32'(xfer_cnt), 32'h55);

    // Backpressure on channel 1: entry holds, new data is not captured.
    do_reset();
    in_valid = 1'b1; sel = 2'd1; din = 2'b01; out_ready = 4'b1101;
    tick();
    din = 2'b10;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t3_in_ready", 32'(in_ready), 32'd0);
      chk("t3_out_valid", 32'(out_valid), 32'b0010);
      chk("t3_dout", 32'(dout), 32'b01);
      tick();
    end
    chk("t3_cnt_hold", 32'(xfer_cnt), 32'd0);
    out_ready = 4'b1111;
    #1 chk("t3_in_ready_up", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("t3_refill_valid", 32'(out_valid), 32'b0010);
    chk("t3_refill_dout", 32'(dout), 32'b10);
    chk("t3_cnt1", 32'(xfer_cnt), 32'h04);
    tick();
    chk("t3_empty", 32'(out_valid), 32'd0);
    chk("t3_cnt2", 32'(xfer_cnt), 32'h08);

    // Counter wrap on channel 0 (CW=2): 1,2,3,0.
    do_reset();
    in_valid = 1'b1; sel = 2'd0; din = 2'b01; out_ready = 4'b1111;
    tick();
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("t4_cnt0", 32'(xfer_cnt), 32'(k % 4));
    end
    in_valid = 1'b0;
    tick();
    chk("t4_cnt0_last", 32'(xfer_cnt), 32'd1);

    // Asynchronous reset while full on channel 3.
    do_reset();
    in_valid = 1'b1; sel = 2'd3; din = 2'b11; out_ready = 4'b1000;
    tick();
    tick();
    in_valid = 1'b0; out_ready = 4'b0000;
    tick();
    chk("t5_full", 32'(out_valid), 32'b1000);
    chk("t5_cnt3", 32'(xfer_cnt), 32'h40);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(out_valid), 32'd0);
    chk("t5_rst_cnt", 32'(xfer_cnt), 32'd0);
    chk("t5_rst_ready", 32'(in_ready), 32'd1);
    chk("t5_rst_dout", 32'(dout), 32'd0);
    #1 rst_n = 1'b1;
    tick();
    chk("t5_post_valid", 32'(out_valid), 32'd0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/demux1_4_hs.md
DEMUX1_4_HS -- requirements
Module: demux1_4_hs

Interface
REQ-001 Parameter DW, default 2, data width in bits (DW >= 1).
REQ-002 Parameter CW, default 8, width of each per-channel transfer counter (CW >= 2).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 sel  input  2  destination channel index 0..3, qualified by in_valid.
REQ-006 din  input  DW  input data, qualified by in_valid.
REQ-007 in_valid  input  1  upstream offers {sel, din}.
REQ-008 in_ready  output  1  block accepts {sel, din} this cycle.
REQ-009 out_valid  output  4  one-hot; bit k = channel k holds valid data.
REQ-010 out_ready  input  4  bit k = channel k consumer accepts.
REQ-011 dout  output  DW  registered data, shared by all four channels.
REQ-012 xfer_cnt  output  4*CW  per-channel completed-transfer counters; channel k at bits [k*CW +: CW].

Function
REQ-013 The block SHALL hold exactly one output register entry {ch_q[1:0], dout, full}, with FSM states EMPTY (full=0) and FULL (full=1).
REQ-014 out_valid SHALL equal (full ? one-hot(ch_q) : 4'b0000); at most one bit is ever set.
REQ-015 Output handshake: channel k completes a transfer in a cycle where out_valid[k]=1 and out_ready[k]=1 (drain).
REQ-016 out_ready bits of channels not addressed by ch_q SHALL be ignored.
REQ-017 in_ready SHALL be combinational: in_ready = ~full | (out_ready[ch_q]).
REQ-018 Input handshake: accept occurs when in_valid=1 and in_ready=1; sel and din are captured on that edge.
REQ-019 Latency: accepted data SHALL appear on dout with out_valid[sel] asserted on the cycle after the accept edge (1 cycle).
REQ-020 EMPTY + accept -> FULL; ch_q <= sel, dout <= din.
REQ-021 EMPTY + no accept -> EMPTY; dout holds its last value.
REQ-022 FULL + drain + no accept -> EMPTY; dout holds its last value.
REQ-023 FULL + drain + accept on the same edge -> FULL with the new {sel, din}; back-to-back throughput is 1 transfer/cycle, including a change of channel.
REQ-024 FULL + no drain -> FULL; ch_q and dout SHALL remain stable (no overwrite), and in_ready=0.
REQ-025 in_valid=0 SHALL never change state; sel and din are don't-care while in_valid=0.
REQ-026 On each drain of channel k, counter k SHALL increment by 1 modulo 2^CW (2^CW-1 wraps to 0); other counters hold.
REQ-027 In a simultaneous drain+accept cycle, only the counter of the draining channel SHALL increment.
REQ-028 The block SHALL have no combinational path from din or sel to any output; the only combinational path to an output is out_ready -> in_ready.

Reset
REQ-029 While rst_n=0: full=0 (state EMPTY), ch_q=0, dout=0, out_valid=4'b0000, all xfer_cnt=0, and in_ready=1.
REQ-030 Reset asserted mid-transfer SHALL discard any held entry immediately (asynchronously), with no completion counted.
REQ-031 After rst_n deasserts, the first rising edge SHALL be able to accept.

Verification
REQ-032 Reset, then in_valid=1, sel=2, din=2'b10, out_ready=4'b0100 for one cycle -> next cycle out_valid=4'b0100, dout=2'b10; following edge EMPTY, xfer_cnt ch2=1.
REQ-033 Stream sel=3,1,0,2 with din=11,01,00,10 on consecutive cycles, out_ready=4'b1111 -> out_valid=1000,0010,0001,0100 on consecutive cycles, in_ready constant 1, each counter=1.
REQ-034 Hold sel=1, din=01 while out_ready=4'b1101 for 5 cycles -> out_valid=0010, dout=01 stable, in_ready=0, a new din=10 is not captured; raising out_ready[1] drains 01 then accepts 10 on the same edge.
REQ-035 Counter wrap with CW=2: 4 drains on channel 0 -> counter reads 1,2,3,0; the other counters stay 0.
REQ-036 Assert rst_n=0 asynchronously between edges while FULL on channel 3 -> out_valid=0000, all counters=0 immediately, before the next edge.
REQ-037 Every cycle, a bench checker SHALL confirm out_valid is zero or one-hot, and that the total drains equals the sum of the counters modulo 2^CW.
